// File: rtl/alu_pkg.sv
// Shared types and constants for the sequential ALU and its iterative datapath.
package alu_pkg;

  // Operation codes, same encoding as the original combinational ALU.
  typedef enum logic [3:0] {
    ALU_NOP  = 4'd0,
    ALU_MOV  = 4'd1,
    ALU_CMP  = 4'd2,
    ALU_TEST = 4'd3,
    ALU_SHL  = 4'd4,
    ALU_SHR  = 4'd5,
    ALU_ADD  = 4'd6,
    ALU_ADC  = 4'd7,
    ALU_SUB  = 4'd8,
    ALU_SBB  = 4'd9,
    ALU_MUL  = 4'd10,
    ALU_AND  = 4'd11,
    ALU_OR   = 4'd12,
    ALU_XOR  = 4'd13,
    ALU_NOT  = 4'd14,
    ALU_CLRF = 4'd15
  } alu_mode_e;

  // Bit positions inside the 8-bit flags register; [3:0] stay zero.
  localparam int FLAG_Z = 7;
  localparam int FLAG_S = 6;
  localparam int FLAG_C = 5;
  localparam int FLAG_O = 4;

  // Control FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_e;

  // True for the operations that run through the iterative datapath.
  function automatic logic is_iter_mode(input alu_mode_e m);
    return (m == ALU_SHL) || (m == ALU_SHR) || (m == ALU_MUL);
  endfunction

endpackage

// File: rtl/seq_alu_iter.sv
// Iterative datapath: one-bit-per-cycle shifts and shift-add multiply.
// Outputs show the value *after* the current step, so the controller can
// capture the final result on the same edge that enters DONE.
module seq_alu_iter
  import alu_pkg::*;
#(
  parameter int WORD_SIZE = 8,
  parameter int CNT_W     = $clog2(WORD_SIZE + 2)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  alu_mode_e            op,
  input  logic [WORD_SIZE-1:0] a,
  input  logic [WORD_SIZE-1:0] b,
  output logic [WORD_SIZE-1:0] result,
  output logic                 carry_out,
  output logic                 hi_nonzero,
  output logic                 last
);

  // prod holds {hi, lo}; shifts only use the low half.
  logic [2*WORD_SIZE-1:0] prod_q, prod_d, step_prod_s;
  logic [WORD_SIZE-1:0]   a_q, a_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d, load_cnt_s;
  alu_mode_e              op_q, op_d;
  logic                   carry_q, carry_d, step_carry_s;
  logic [WORD_SIZE:0]     mul_sum_s;

  // One iteration step of the latched operation.
  always_comb begin
    step_prod_s  = prod_q;
    step_carry_s = carry_q;
    mul_sum_s    = '0;
    case (op_q)
      ALU_SHL: begin
        step_prod_s  = {prod_q[2*WORD_SIZE-1:WORD_SIZE], prod_q[WORD_SIZE-2:0], 1'b0};
        step_carry_s = prod_q[WORD_SIZE-1];
      end
      ALU_SHR: begin
        step_prod_s  = {prod_q[2*WORD_SIZE-1:WORD_SIZE], 1'b0, prod_q[WORD_SIZE-1:1]};
        step_carry_s = prod_q[0];
      end
      ALU_MUL: begin
        // Add the multiplicand when the current multiplier bit is set,
        // then shift the whole {carry, hi, lo} right by one.
        mul_sum_s   = {1'b0, prod_q[2*WORD_SIZE-1:WORD_SIZE]}
                    + (prod_q[0] ? {1'b0, a_q} : {(WORD_SIZE+1){1'b0}});
        step_prod_s = {mul_sum_s, prod_q[WORD_SIZE-1:1]};
      end
      default: begin
        step_prod_s  = prod_q;
        step_carry_s = carry_q;
      end
    endcase
  end

  // Iteration count: WORD_SIZE for MUL, min(b, WORD_SIZE+1) for shifts.
  always_comb begin
    if (op == ALU_MUL) begin
      load_cnt_s = CNT_W'(WORD_SIZE);
    end else if (b > WORD_SIZE'(WORD_SIZE + 1)) begin
      load_cnt_s = CNT_W'(WORD_SIZE + 1);
    end else begin
      load_cnt_s = CNT_W'(b);
    end
  end

  // Load operands on accept, otherwise step while the counter runs.
  always_comb begin
    prod_d  = prod_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    if (load) begin
      op_d    = op;
      a_d     = a;
      cnt_d   = load_cnt_s;
      carry_d = 1'b0;
      if (op == ALU_MUL) begin
        prod_d = {{WORD_SIZE{1'b0}}, b};
      end else begin
        prod_d = {{WORD_SIZE{1'b0}}, a};
      end
    end else if (cnt_q != {CNT_W{1'b0}}) begin
      prod_d  = step_prod_s;
      carry_d = step_carry_s;
      cnt_d   = cnt_q - CNT_W'(1);
    end else begin
      prod_d  = prod_q;
      carry_d = carry_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      op_q    <= ALU_NOP;
      a_q     <= '0;
    end else begin
      prod_q  <= prod_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
    end
  end

  assign result     = step_prod_s[WORD_SIZE-1:0];
  assign carry_out  = step_carry_s;
  assign hi_nonzero = |step_prod_s[2*WORD_SIZE-1:WORD_SIZE];
  assign last       = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/seq_alu.sv
// Registered 16-mode ALU with a flags register and an iterative shift/multiply
// unit behind a start/ready/done handshake.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WORD_SIZE = 8,
  parameter int CNT_W     = $clog2(WORD_SIZE + 2)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [3:0]           mode_select,
  input  logic [WORD_SIZE-1:0] input_A,
  input  logic [WORD_SIZE-1:0] input_B,
  output logic                 ready,
  output logic                 done,
  output logic [WORD_SIZE-1:0] output_C,
  output logic [7:0]           flags
);

  localparam int MSB = WORD_SIZE - 1;

  state_e               state_q, state_d;
  alu_mode_e            mode_q, mode_d, mode_s;
  logic [WORD_SIZE-1:0] out_q, out_d;
  logic [7:0]           flags_q, flags_d;
  logic                 ready_q, ready_d;
  logic                 done_q, done_d;

  logic                 cin_s;
  logic [WORD_SIZE:0]   sum_s, diff_s;
  logic [WORD_SIZE-1:0] logic_s;
  logic                 iter_load_s;
  logic [WORD_SIZE-1:0] iter_result_s;
  logic                 iter_carry_s, iter_hi_nz_s, iter_last_s;

  assign mode_s = alu_mode_e'(mode_select);
  assign cin_s  = flags_q[FLAG_C];

  // Wide add/subtract; only ADC/SBB fold in the carry-in, so the MSB of the
  // (WORD_SIZE+1)-bit result is the carry or borrow directly.
  always_comb begin
    sum_s  = {1'b0, input_A} + {1'b0, input_B}
           + {{WORD_SIZE{1'b0}}, (mode_s == ALU_ADC) & cin_s};
    diff_s = {1'b0, input_A} - {1'b0, input_B}
           - {{WORD_SIZE{1'b0}}, (mode_s == ALU_SBB) & cin_s};
    case (mode_s)
      ALU_TEST, ALU_AND: logic_s = input_A & input_B;
      ALU_OR:            logic_s = input_A | input_B;
      ALU_XOR:           logic_s = input_A ^ input_B;
      default:           logic_s = input_A & input_B;
    endcase
  end

  // Next state, result and flags; single-cycle ops resolve on the accept edge.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    out_d       = out_q;
    flags_d     = flags_q;
    iter_load_s = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          mode_d  = mode_s;
          state_d = DONE;
          case (mode_s)
            ALU_NOP: out_d = out_q;
            ALU_MOV: out_d = input_B;
            ALU_CMP: begin
              flags_d[FLAG_Z] = (diff_s[MSB:0] == {WORD_SIZE{1'b0}});
              flags_d[FLAG_S] = diff_s[MSB];
              flags_d[FLAG_C] = diff_s[WORD_SIZE];
              flags_d[FLAG_O] = (input_A[MSB] != input_B[MSB]) && (diff_s[MSB] != input_A[MSB]);
            end
            ALU_TEST: begin
              flags_d[FLAG_Z] = (logic_s == {WORD_SIZE{1'b0}});
              flags_d[FLAG_S] = logic_s[MSB];
              flags_d[FLAG_C] = 1'b0;
              flags_d[FLAG_O] = 1'b0;
            end
            ALU_SHL, ALU_SHR: begin
              if (input_B == {WORD_SIZE{1'b0}}) begin
                out_d = input_A;
              end else begin
                iter_load_s = 1'b1;
                state_d     = ITER;
              end
            end
            ALU_ADD, ALU_ADC: begin
              out_d           = sum_s[MSB:0];
              flags_d[FLAG_Z] = (sum_s[MSB:0] == {WORD_SIZE{1'b0}});
              flags_d[FLAG_S] = sum_s[MSB];
              flags_d[FLAG_C] = sum_s[WORD_SIZE];
              flags_d[FLAG_O] = (input_A[MSB] == input_B[MSB]) && (sum_s[MSB] != input_A[MSB]);
            end
            ALU_SUB, ALU_SBB: begin
              out_d           = diff_s[MSB:0];
              flags_d[FLAG_Z] = (diff_s[MSB:0] == {WORD_SIZE{1'b0}});
              flags_d[FLAG_S] = diff_s[MSB];
              flags_d[FLAG_C] = diff_s[WORD_SIZE];
              flags_d[FLAG_O] = (input_A[MSB] != input_B[MSB]) && (diff_s[MSB] != input_A[MSB]);
            end
            ALU_MUL: begin
              iter_load_s = 1'b1;
              state_d     = ITER;
            end
            ALU_AND, ALU_OR, ALU_XOR: begin
              out_d           = logic_s;
              flags_d[FLAG_Z] = (logic_s == {WORD_SIZE{1'b0}});
              flags_d[FLAG_S] = logic_s[MSB];
              flags_d[FLAG_C] = 1'b0;
              flags_d[FLAG_O] = 1'b0;
            end
            ALU_NOT:  out_d   = ~input_A;
            ALU_CLRF: flags_d = 8'h00;
            default:  out_d   = out_q;
          endcase
        end else begin
          state_d = IDLE;
        end
      end
      ITER: begin
        if (iter_last_s) begin
          state_d         = DONE;
          out_d           = iter_result_s;
          flags_d[FLAG_Z] = (iter_result_s == {WORD_SIZE{1'b0}});
          flags_d[FLAG_S] = iter_result_s[MSB];
          if (mode_q == ALU_MUL) begin
            flags_d[FLAG_C] = iter_hi_nz_s;
            flags_d[FLAG_O] = iter_hi_nz_s;
          end else begin
            flags_d[FLAG_C] = iter_carry_s;
          end
        end else begin
          state_d = ITER;
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d != ITER);
    done_d  = (state_d == DONE);
  end

  // Control and architectural registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= ALU_NOP;
      out_q   <= '0;
      flags_q <= 8'h00;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      out_q   <= out_d;
      flags_q <= flags_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  seq_alu_iter #(
    .WORD_SIZE (WORD_SIZE),
    .CNT_W     (CNT_W)
  ) u_iter (
    .clk        (clk),
    .rst        (rst),
    .load       (iter_load_s),
    .op         (mode_s),
    .a          (input_A),
    .b          (input_B),
    .result     (iter_result_s),
    .carry_out  (iter_carry_s),
    .hi_nonzero (iter_hi_nz_s),
    .last       (iter_last_s)
  );

  assign ready    = ready_q;
  assign done     = done_q;
  assign output_C = out_q;
  assign flags    = flags_q;

endmodule
